// File: rtl/pc_sequencer.sv
// Program counter sequencer with a prioritized trap/jump/call/ret/branch/advance update.
// Define PC_SEQUENCER_RAS_EN to build the circular return-address stack; otherwise call acts as jump.
module pc_sequencer #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = 'h0,
    parameter logic [WIDTH-1:0]  STRIDE       = 'h4,
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = 'h100,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_address_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_offset_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             trap_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_overflow_o,
    output logic             ras_underflow_o
);

    logic [WIDTH-1:0] pc_q, pc_d, pc_seq;

    assign pc_seq = pc_q + STRIDE;
    assign pc_o   = pc_q;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // top_q is the next slot to write; when full it also points at the oldest entry,
    // so a push while full overwrites the oldest return address.
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, ovf_d, udf_d;
    logic             empty_q, full_q, ovf_q, udf_q;

    assign top_inc = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
    assign top_dec = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - 1'b1;

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (trap_i) begin
            pc_d = TRAP_VECTOR;
        end else if (jump_i) begin
            pc_d = jump_address_i;
        end else if (call_i) begin
            pc_d  = jump_address_i;
            push  = 1'b1;
            top_d = top_inc;
            if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
            else                            cnt_d = cnt_q + 1'b1;
        end else if (ret_i) begin
            if (cnt_q == '0) begin
                udf_d = 1'b1;
            end else begin
                pc_d  = stack_q[top_dec];
                top_d = top_dec;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (branch_i) begin
            pc_d = pc_q + branch_offset_i;
        end else if (enable_i) begin
            pc_d = pc_seq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Entry storage is not reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) stack_q[top_q] <= pc_seq;
    end

    assign ras_empty_o     = empty_q;
    assign ras_full_o      = full_q;
    assign ras_overflow_o  = ovf_q;
    assign ras_underflow_o = udf_q;
`else
    // No stack: call degenerates to jump, ret still blocks lower-priority requests but holds pc.
    always_comb begin
        pc_d = pc_q;
        if (trap_i)                 pc_d = TRAP_VECTOR;
        else if (jump_i || call_i)  pc_d = jump_address_i;
        else if (ret_i)             pc_d = pc_q;
        else if (branch_i)          pc_d = pc_q + branch_offset_i;
        else if (enable_i)          pc_d = pc_seq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_VECTOR;
        else        pc_q <= pc_d;
    end

    assign ras_empty_o     = 1'b1;
    assign ras_full_o      = 1'b0;
    assign ras_overflow_o  = 1'b0;
    assign ras_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Random plus directed stimulus for pc_sequencer, checked against a queue-based reference model.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0, jump_i = 1'b0, branch_i = 1'b0;
    logic        call_i = 1'b0, ret_i = 1'b0, trap_i = 1'b0;
    logic [31:0] jump_address_i = '0, branch_offset_i = '0;
    logic [31:0] pc_o;
    logic        ras_empty_o, ras_full_o, ras_overflow_o, ras_underflow_o;

    pc_sequencer #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .STRIDE(32'h4),
        .TRAP_VECTOR(32'h100), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .enable_i(enable_i), .jump_i(jump_i), .jump_address_i(jump_address_i),
        .branch_i(branch_i), .branch_offset_i(branch_offset_i),
        .call_i(call_i), .ret_i(ret_i), .trap_i(trap_i),
        .pc_o(pc_o), .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
        .ras_overflow_o(ras_overflow_o), .ras_underflow_o(ras_underflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pc as a plain number, stack as a queue of return addresses.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_stack [$];
    bit          m_ovf = 1'b0, m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc_o, m_pc);
        chk({tag, ".empty"}, 32'(ras_empty_o), 32'(m_stack.size() == 0));
        chk({tag, ".full"}, 32'(ras_full_o), 32'(m_stack.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(ras_overflow_o), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(ras_underflow_o), 32'(m_udf));
    endtask

    task automatic model_step();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (trap_i) m_pc = 32'h100;
        else if (jump_i) m_pc = jump_address_i;
        else if (call_i) begin
            if (RAS_EN) begin
                m_stack.push_back(m_pc + 32'd4);
                if (m_stack.size() > DEPTH) begin
                    m_stack.delete(0);
                    m_ovf = 1'b1;
                end
            end
            m_pc = jump_address_i;
        end else if (ret_i) begin
            if (RAS_EN) begin
                if (m_stack.size() == 0) m_udf = 1'b1;
                else m_pc = m_stack.pop_back();
            end
        end else if (branch_i) m_pc = m_pc + branch_offset_i;
        else if (enable_i) m_pc = m_pc + 32'd4;
    endtask

    task automatic idle();
        {enable_i, jump_i, branch_i, call_i, ret_i, trap_i} = '0;
    endtask

    // One clock: model consumes the same sampled inputs, outputs checked 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_all(tag);
        idle();
    endtask

    task automatic do_jump(input logic [31:0] a);
        idle(); jump_i = 1'b1; jump_address_i = a; tick("jump");
    endtask

    task automatic do_call(input logic [31:0] a);
        idle(); call_i = 1'b1; jump_address_i = a; tick("call");
    endtask

    task automatic do_ret();
        idle(); ret_i = 1'b1; tick("ret");
    endtask

    task automatic do_en();
        idle(); enable_i = 1'b1; tick("en");
    endtask

    // Assert reset between edges, check the asynchronous effect, hold it across an edge
    // with requests active, then release away from the edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        m_pc = 32'h0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        chk_all({tag, ".async"});
        enable_i = 1'b1; call_i = 1'b1; jump_address_i = 32'h5555_0000;
        @(posedge clk);
        #1;
        chk_all({tag, ".held"});
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        #1;
        chk_all("reset");
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // idle 3, enable 3
        repeat (3) tick("idle");
        chk("r039.idle", pc_o, 32'h0);
        repeat (3) do_en();
        chk("r039.en", pc_o, 32'hC);

        // call/ret round trip
        do_jump(32'h10);
        do_call(32'h200);
        do_en(); do_en();
        do_ret();

        // overflow then full drain and underflow
        do_jump(32'h0);
        for (int i = 1; i <= 5; i++) do_call(32'(i) << 12);
        repeat (5) do_ret();

        // branch backwards and pc wrap
        do_jump(32'h100);
        idle(); branch_i = 1'b1; branch_offset_i = 32'hFFFF_FFF0; tick("branch");
        chk("r042.branch", pc_o, 32'hF0);
        do_jump(32'hFFFF_FFFC);
        do_en();
        chk("r042.wrap", pc_o, 32'h0);

        // priority
        do_call(32'h40);
        idle(); trap_i = 1'b1; jump_i = 1'b1; call_i = 1'b1; enable_i = 1'b1;
        jump_address_i = 32'hABCD_1234; tick("prio.trap");
        chk("r043.trap", pc_o, 32'h100);
        idle(); jump_i = 1'b1; enable_i = 1'b1; jump_address_i = 32'hABCD_1234; tick("prio.jump");
        chk("r043.jump", pc_o, 32'hABCD_1234);
        idle(); call_i = 1'b1; ret_i = 1'b1; jump_address_i = 32'h300; tick("prio.callret");
        idle(); ret_i = 1'b1; branch_i = 1'b1; branch_offset_i = 32'h8; tick("prio.retbr");

        // reset mid-operation with two live entries
        do_jump(32'h20);
        do_call(32'h80);
        do_call(32'h90);
        mid_reset("r044");
        chk("r044.pc", pc_o, 32'h0);
        do_ret();

        // randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                mid_reset("rand.rst");
            end else begin
                idle();
                trap_i          = ($urandom_range(0, 99) < 3);
                jump_i          = ($urandom_range(0, 99) < 8);
                call_i          = ($urandom_range(0, 99) < 18);
                ret_i           = ($urandom_range(0, 99) < 18);
                branch_i        = ($urandom_range(0, 99) < 12);
                enable_i        = ($urandom_range(0, 99) < 60);
                jump_address_i  = $urandom;
                branch_offset_i = $urandom;
                tick("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
